// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670-style RGB565 pixel source: generates vsync/href/data framing
// with selectable test patterns for exercising the camera capture path.
module ov7670_stream_gen #(
  parameter int H_ACTIVE  = 160,
  parameter int V_ACTIVE  = 120,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_LEN = 3,
  parameter int V_BACK    = 17,
  parameter int V_FRONT   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  input  logic [9:0]  box_x,
  input  logic [9:0]  box_y,
  input  logic [9:0]  box_size,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int CW   = $clog2(LINE);
  localparam int M1   = (V_ACTIVE > VSYNC_LEN) ? V_ACTIVE : VSYNC_LEN;
  localparam int M2   = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int VMAX = (M1 > M2) ? M1 : M2;
  localparam int LW   = $clog2(VMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [LW-1:0] row_q, row_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   solid_q, solid_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d, bs_q, bs_d;
  logic          vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic [LW-1:0] last_row;
  logic          last_col, phase_end, latch_cfg;
  logic [10:0]   px, py;
  logic [2:0]    bar_idx;
  logic          in_box;
  logic [15:0]   pix;

  // Position/state for the next cycle is computed first; registered outputs
  // are then derived from that next position so they line up with state_q.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    row_d     = row_q;
    fcnt_d    = fcnt_q;
    latch_cfg = 1'b0;

    case (state_q)
      S_VSYNC:  last_row = LW'(VSYNC_LEN - 1);
      S_VBACK:  last_row = LW'(V_BACK - 1);
      S_ACTIVE: last_row = LW'(V_ACTIVE - 1);
      S_VFRONT: last_row = LW'(V_FRONT - 1);
      default:  last_row = '0;
    endcase
    last_col  = (cyc_q == CW'(LINE - 1));
    phase_end = last_col && (row_q == last_row);

    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d   = S_VSYNC;
        cyc_d     = '0;
        row_d     = '0;
        latch_cfg = 1'b1;
      end
    end else if (last_col) begin
      cyc_d = '0;
      if (phase_end) begin
        row_d = '0;
        case (state_q)
          S_VSYNC:  state_d = S_VBACK;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFRONT;
          default: begin
            fcnt_d = fcnt_q + 16'd1;
            if (enable) begin
              state_d   = S_VSYNC;
              latch_cfg = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        endcase
      end else begin
        row_d = row_q + LW'(1);
      end
    end else begin
      cyc_d = cyc_q + CW'(1);
    end

    sel_d   = latch_cfg ? pattern_sel : sel_q;
    solid_d = latch_cfg ? solid_rgb   : solid_q;
    bx_d    = latch_cfg ? box_x       : bx_q;
    by_d    = latch_cfg ? box_y       : by_q;
    bs_d    = latch_cfg ? box_size    : bs_q;
  end

  always_comb begin
    px      = 11'(cyc_d >> 1);
    py      = 11'(row_d);
    bar_idx = 3'((32'(px) * 32'd8) / 32'(H_ACTIVE));
    // 11-bit compare keeps box_x+box_size from wrapping; size 0 is empty.
    in_box  = (px >= {1'b0, bx_d}) && (px < ({1'b0, bx_d} + {1'b0, bs_d})) &&
              (py >= {1'b0, by_d}) && (py < ({1'b0, by_d} + {1'b0, bs_d}));

    case (sel_d)
      2'd0: pix = solid_d;
      2'd1: begin
        case (bar_idx)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd2:    pix = {px[4:0], py[5:0], px[4:0]};
      default: pix = in_box ? 16'hF800 : 16'hFFFF;
    endcase

    vsync_d = (state_d == S_VSYNC);
    busy_d  = (state_d != S_IDLE);
    href_d  = (state_d == S_ACTIVE) && (cyc_d < CW'(2 * H_ACTIVE));
    done_d  = (state_d == S_VFRONT) && (cyc_d == CW'(LINE - 1)) &&
              (row_d == LW'(V_FRONT - 1));
    data_d  = '0;
    if (href_d) data_d = cyc_d[0] ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      row_q   <= '0;
      sel_q   <= '0;
      solid_q <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bs_q    <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      solid_q <= solid_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bs_q    <= bs_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: doc/ov7670_stream_gen.md
Name: ov7670_stream_gen

Overview:
- Synthetic OV7670-compatible pixel source: drives cam_vsync, cam_href and cam_data (RGB565, two bytes per pixel, high byte first) with the same framing the camera presents to the capture/memory-controller path.
- Used as the transmit end of the camera interface for bring-up and regression of capture → frame buffer → Red_Check/Dice_Reader without a physical sensor.
- Selectable test patterns, including a red box that emulates a die face.

Parameters:
- H_ACTIVE, 160: active pixels per line.
- V_ACTIVE, 120: active lines per frame.
- H_BLANK, 144: href-low cycles after each line's active bytes.
- VSYNC_LEN, 3: line periods with cam_vsync high.
- V_BACK, 17: line periods after vsync before the first active line.
- V_FRONT, 10: line periods after the last active line.

Ports:
- clk  in  1  byte clock; also acts as cam_pclk for the consumer, which samples on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run frames; sampled only at frame boundaries.
- pattern_sel  in  2  0 solid, 1 colour bars, 2 gradient, 3 box.
- solid_rgb  in  16  RGB565 colour for pattern 0.
- box_x  in  10  box left column.
- box_y  in  10  box top line.
- box_size  in  10  box edge length in pixels.
- cam_vsync  out  1  frame sync, active high.
- cam_href  out  1  line valid.
- cam_data  out  8  pixel byte.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_cnt  out  16  frames completed, wraps.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- LINE = 2*H_ACTIVE + H_BLANK cycles.
- All outputs are registered.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE: if enable=1 at cycle N, enter VSYNC; cam_vsync=1 and busy=1 from cycle N+1.
  - VSYNC: lasts VSYNC_LEN*LINE cycles with cam_vsync=1, href=0, then VBACK.
  - VBACK: lasts V_BACK*LINE cycles with all syncs low, then ACTIVE.
  - ACTIVE: V_ACTIVE lines. In each line, cam_href=1 for exactly 2*H_ACTIVE consecutive cycles, then 0 for H_BLANK cycles. After the last line's blanking, enter VFRONT.
  - VFRONT: lasts V_FRONT*LINE cycles. On its last cycle:
    - frame_done=1 for that one cycle;
    - frame_cnt increments (mod 2^16), visible the next cycle;
    - enable is sampled: if 1, next state is VSYNC (back-to-back frames, busy stays 1); if 0, next state is IDLE (busy=0).
- Deasserting enable mid-frame does not truncate the frame; it always completes.
- pattern_sel, solid_rgb, box_x, box_y and box_size are latched on entry to VSYNC. Changes mid-frame have no effect until the next frame.
- Byte order: for pixel x on active line y, byte 2x carries pix[15:8] and byte 2x+1 carries pix[7:0].
- cam_data = 8'h00 whenever cam_href=0.
- Patterns, with x in 0..H_ACTIVE-1 and y in 0..V_ACTIVE-1:
  - 0: pix = solid_rgb.
  - 1: eight bars, bar index = x*8/H_ACTIVE (integer). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2: pix = {x[4:0], y[5:0], x[4:0]}.
  - 3: pix = F800 when box_x ≤ x ≤ box_x+box_size-1 and box_y ≤ y ≤ box_y+box_size-1, else FFFF.
    - Compare in 11 bits, no wrap.
    - box_size=0 produces no box.
    - Box portions past the image edge are clipped.
- Reset mid-frame: next cycle all outputs return to reset values and the FSM is in IDLE. No partial-frame frame_done pulse.
- Bytes per frame: exactly 2*H_ACTIVE*V_ACTIVE; with defaults, 38400 (19200 capture words).

Test Plan:
All scenarios use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LEN=1, V_BACK=1, V_FRONT=1, giving LINE=20 and frame=140 cycles.

1. Release reset, enable=0 for 50 cycles → all outputs 0. Raise enable at cycle N → cam_vsync high for cycles N+1..N+20; first href rise at N+41; frame_done pulses at N+140; frame_cnt=1.
2. Pattern 0, solid_rgb=16'hA55A, 1 frame → 4 href bursts of 16 cycles each, bytes alternating A5,5A; 64 bytes total; cam_data=00 in every blank cycle.
3. Pattern 1 → line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00, identical on all 4 lines.
4. Pattern 3, box_x=6, box_y=2, box_size=4 → pixels x=6..7 on lines 2..3 are F800, all others FFFF (clipping). Repeat with box_size=0 → all FFFF.
5. Hold enable=1 for 3 frames while changing pattern_sel mid-frame 1 → 3 frame_done pulses 140 cycles apart; cam_vsync rises the cycle after each pulse; the new pattern first appears in frame 2.
6. Assert reset during ACTIVE line 2 → next cycle href=vsync=busy=0, no frame_done. Re-enable → a full frame with correct timing from VSYNC; frame_cnt counts from 0.
